// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//
// This interface bundles the signals between the multicycle control unit and
// its datapath.
//
// The master modport is the control unit. It takes the instruction fields and
// the branch flag, and it drives every datapath enable and select.
// The slave modport is the datapath side, which is the mirror image.
//
// Signals
//   program_mode          ctrl <- dp   1 = stream instructions into imem
//   opcode[3:0]           ctrl <- dp   opcode field of the instruction register
//   result_lsb            ctrl <- dp   LSB of ALU output register (branch cond)
//   ir_enable             ctrl -> dp   load instruction register
//   dmem_read             ctrl -> dp   data memory read strobe
//   dmem_write            ctrl -> dp   data memory write strobe
//   imem_read             ctrl -> dp   instruction memory read strobe
//   imem_write            ctrl -> dp   instruction memory write strobe
//   pc_increment          ctrl -> dp   PC <= PC + 1
//   alu_reg_enable        ctrl -> dp   latch register-file operands A/B
//   pc_enable             ctrl -> dp   PC <= branch/jump target
//   alu_src_B             ctrl -> dp   ALU B mux: 0 = reg B, 1 = immediate
//   alu_out_reg_enable    ctrl -> dp   latch ALU result
//   dmem_out_reg_enable   ctrl -> dp   latch data-memory output
//   reg_write_enable      ctrl -> dp   register-file write
//   select_reg_write_data ctrl -> dp   writeback source (0 ALU, 1 dmem, 2 imm)
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic       program_mode;
    logic [3:0] opcode;
    logic       result_lsb;

    logic       ir_enable;
    logic       dmem_read;
    logic       dmem_write;
    logic       imem_read;
    logic       imem_write;
    logic       pc_increment;
    logic       alu_reg_enable;
    logic       pc_enable;
    logic       alu_src_B;
    logic       alu_out_reg_enable;
    logic       dmem_out_reg_enable;
    logic       reg_write_enable;
    logic [1:0] select_reg_write_data;

    modport master (
        input  program_mode, opcode, result_lsb,
        output ir_enable, dmem_read, dmem_write, imem_read, imem_write,
               pc_increment, alu_reg_enable, pc_enable, alu_src_B,
               alu_out_reg_enable, dmem_out_reg_enable, reg_write_enable,
               select_reg_write_data
    );

    modport slave (
        output program_mode, opcode, result_lsb,
        input  ir_enable, dmem_read, dmem_write, imem_read, imem_write,
               pc_increment, alu_reg_enable, pc_enable, alu_src_B,
               alu_out_reg_enable, dmem_out_reg_enable, reg_write_enable,
               select_reg_write_data
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// This is a Moore control unit for a multicycle CPU with a 4-bit opcode.
// It steps each instruction through fetch, decode, execute, memory and
// writeback. It drives every datapath enable and select from the current
// state.
// A program mode streams words into instruction memory. During program mode
// the unit writes imem and bumps the PC on every cycle.
//
// Ports
//   clk    in  system clock, all state updates on the rising edge
//   reset  in  asynchronous, active-high; forces FETCH and zeroes all outputs
//   ctrl   multicycle_control_if.master, instruction fields in and
//          datapath controls out
//
// Cycles per instruction: NOP/reserved 2, JUMP/LI 3, R-type/ADDI/BRZ/STORE 4,
// LOAD 5.
// ---------------------------------------------------------------------------
module multicycle_control (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master ctrl
);

    // Opcode map
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_ADDI  = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_BRZ   = 4'd10;
    localparam logic [3:0] OP_JUMP  = 4'd11;
    localparam logic [3:0] OP_LI    = 4'd12;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // Writeback source select
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_DMEM = 2'd1;
    localparam logic [1:0] WB_SEL_IMM  = 2'd2;

    // Binary state encoding. Encoding 4'd15 is unused, and the next-state
    // default sends it back to FETCH.
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_EXEC_I    = 4'd3,
        ST_WB_ALU    = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_READ  = 4'd6,
        ST_WB_MEM    = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_BR_CMP    = 4'd9,
        ST_BR_TAKE   = 4'd10,
        ST_JUMP      = 4'd11,
        ST_LI_WB     = 4'd12,
        ST_HALT      = 4'd13,
        ST_PROGRAM   = 4'd14
    } state_t;

    state_t state;
    state_t next_state;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other signal.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: next_state is given a default before the case. Because of that,
    // every path through this block assigns it, and no latch is inferred.
    always_comb begin
        next_state = ST_FETCH;

        case (state)
            ST_FETCH: begin
                next_state = ST_DECODE;
            end

            ST_DECODE: begin
                case (ctrl.opcode)
                    OP_ADD, OP_SUB, OP_AND,
                    OP_OR, OP_XOR, OP_SLT:  next_state = ST_EXEC_R;
                    OP_ADDI:                next_state = ST_EXEC_I;
                    OP_LOAD, OP_STORE:      next_state = ST_MEM_ADDR;
                    OP_BRZ:                 next_state = ST_BR_CMP;
                    OP_JUMP:                next_state = ST_JUMP;
                    OP_LI:                  next_state = ST_LI_WB;
                    OP_HALT:                next_state = ST_HALT;
                    // NOP and the reserved opcodes 13/14 finish after decode.
                    default:                next_state = ST_FETCH;
                endcase
            end

            ST_EXEC_R, ST_EXEC_I: begin
                next_state = ST_WB_ALU;
            end

            ST_MEM_ADDR: begin
                // The opcode is looked at a second time here so that LOAD and
                // STORE can share the address cycle. Any other opcode cannot
                // reach this state, and it is sent back to FETCH.
                if (ctrl.opcode == OP_LOAD) begin
                    next_state = ST_MEM_READ;
                end else if (ctrl.opcode == OP_STORE) begin
                    next_state = ST_MEM_WRITE;
                end else begin
                    next_state = ST_FETCH;
                end
            end

            ST_MEM_READ: begin
                next_state = ST_WB_MEM;
            end

            ST_BR_CMP: begin
                next_state = ST_BR_TAKE;
            end

            ST_HALT: begin
                // Only reset or program mode leaves HALT. The program-mode
                // override below handles the second of these.
                next_state = ST_HALT;
            end

            ST_PROGRAM: begin
                // This is the exit taken once program_mode drops. While
                // program_mode stays high, the override below keeps the unit
                // here.
                next_state = ST_FETCH;
            end

            // WB_ALU, WB_MEM, MEM_WRITE, BR_TAKE, JUMP and LI_WB all finish
            // the instruction. The unused encoding also recovers to FETCH.
            default: begin
                next_state = ST_FETCH;
            end
        endcase

        // Program mode wins over everything else. Any in-flight instruction is
        // abandoned at this edge, so none of its later strobes are issued.
        if (ctrl.program_mode) begin
            next_state = ST_PROGRAM;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode (Moore). BR_TAKE is the one exception: there, pc_enable
    // passes result_lsb straight through.
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl.ir_enable             = 1'b0;
        ctrl.dmem_read             = 1'b0;
        ctrl.dmem_write            = 1'b0;
        ctrl.imem_read             = 1'b0;
        ctrl.imem_write            = 1'b0;
        ctrl.pc_increment          = 1'b0;
        ctrl.alu_reg_enable        = 1'b0;
        ctrl.pc_enable             = 1'b0;
        ctrl.alu_src_B             = 1'b0;
        ctrl.alu_out_reg_enable    = 1'b0;
        ctrl.dmem_out_reg_enable   = 1'b0;
        ctrl.reg_write_enable      = 1'b0;
        ctrl.select_reg_write_data = WB_SEL_ALU;

        // During reset the state register already holds FETCH. Without this
        // gate the FETCH strobes would show while reset is still high, so the
        // outputs are held at 0 until reset is released.
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    ctrl.imem_read    = 1'b1;
                    ctrl.ir_enable    = 1'b1;
                    ctrl.pc_increment = 1'b1;
                end
                ST_DECODE: begin
                    ctrl.alu_reg_enable = 1'b1;
                end
                ST_EXEC_R, ST_BR_CMP: begin
                    ctrl.alu_out_reg_enable = 1'b1;
                end
                ST_EXEC_I, ST_MEM_ADDR: begin
                    ctrl.alu_src_B          = 1'b1;
                    ctrl.alu_out_reg_enable = 1'b1;
                end
                ST_WB_ALU: begin
                    ctrl.reg_write_enable      = 1'b1;
                    ctrl.select_reg_write_data = WB_SEL_ALU;
                end
                ST_MEM_READ: begin
                    ctrl.dmem_read           = 1'b1;
                    ctrl.dmem_out_reg_enable = 1'b1;
                end
                ST_WB_MEM: begin
                    ctrl.reg_write_enable      = 1'b1;
                    ctrl.select_reg_write_data = WB_SEL_DMEM;
                end
                ST_MEM_WRITE: begin
                    ctrl.dmem_write = 1'b1;
                end
                ST_BR_TAKE: begin
                    ctrl.pc_enable = ctrl.result_lsb;
                end
                ST_JUMP: begin
                    ctrl.pc_enable = 1'b1;
                end
                ST_LI_WB: begin
                    ctrl.reg_write_enable      = 1'b1;
                    ctrl.select_reg_write_data = WB_SEL_IMM;
                end
                ST_PROGRAM: begin
                    ctrl.imem_write   = 1'b1;
                    ctrl.pc_increment = 1'b1;
                end
                // HALT and the unused encoding drive nothing.
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// This is the self-checking bench for multicycle_control.
// Each test task pushes one entry per clock cycle onto a scoreboard queue.
// An entry holds the inputs for that cycle and the output vector expected in
// that cycle. run_scoreboard then replays the entries one cycle at a time.
// In each cycle it drives the inputs just after the rising edge and compares
// the outputs at the falling edge.
// Two checks are made inline, inside a single clock phase: the reset-time
// check and the asynchronous reset pulse.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic clk;
    logic reset;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector:
    // {ir, dmem_rd, dmem_wr, imem_rd | imem_wr, pc_inc, alu_reg, pc_en |
    //  alu_src_B, alu_out, dmem_out, reg_we | select[1:0]}
    logic [13:0] obs;
    assign obs = {bus.ir_enable, bus.dmem_read, bus.dmem_write, bus.imem_read,
                  bus.imem_write, bus.pc_increment, bus.alu_reg_enable,
                  bus.pc_enable, bus.alu_src_B, bus.alu_out_reg_enable,
                  bus.dmem_out_reg_enable, bus.reg_write_enable,
                  bus.select_reg_write_data};

    localparam logic [13:0] E_ZERO      = 14'b0000_0000_0000_00;
    localparam logic [13:0] E_FETCH     = 14'b1001_0100_0000_00;
    localparam logic [13:0] E_DECODE    = 14'b0000_0010_0000_00;
    localparam logic [13:0] E_EXEC_R    = 14'b0000_0000_0100_00;
    localparam logic [13:0] E_EXEC_I    = 14'b0000_0000_1100_00;
    localparam logic [13:0] E_WB_ALU    = 14'b0000_0000_0001_00;
    localparam logic [13:0] E_MEM_READ  = 14'b0100_0000_0010_00;
    localparam logic [13:0] E_WB_MEM    = 14'b0000_0000_0001_01;
    localparam logic [13:0] E_MEM_WRITE = 14'b0010_0000_0000_00;
    localparam logic [13:0] E_PC_EN     = 14'b0000_0001_0000_00;
    localparam logic [13:0] E_LI_WB     = 14'b0000_0000_0001_10;
    localparam logic [13:0] E_PROGRAM   = 14'b0000_1100_0000_00;

    typedef struct {
        logic        rst;
        logic        pm;
        logic [3:0]  opc;
        logic        lsb;
        logic [13:0] exp;
        string       name;
    } entry_t;

    entry_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic push(input logic rst, input logic pm, input logic [3:0] opc,
                        input logic lsb, input logic [13:0] exp, input string name);
        entry_t e;
        e.rst  = rst;
        e.pm   = pm;
        e.opc  = opc;
        e.lsb  = lsb;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    // This is the shorthand for a normal-running cycle (no reset, no program
    // mode).
    task automatic run(input logic [3:0] opc, input logic [13:0] exp, input string name);
        push(1'b0, 1'b0, opc, 1'b0, exp, name);
    endtask

    task automatic run_scoreboard();
        entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            reset           = e.rst;
            bus.program_mode = e.pm;
            bus.opcode      = e.opc;
            bus.result_lsb  = e.lsb;
            @(negedge clk);
            n_checks++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (obs !== E_ZERO) begin
            n_fail++;
            $display("FAIL reset_initial: got %b expected %b", obs, E_ZERO);
        end
        push(1'b1, 1'b0, 4'd3, 1'b0, E_ZERO, "reset_hold_0");
        push(1'b1, 1'b0, 4'd3, 1'b0, E_ZERO, "reset_hold_1");
        run_scoreboard();
    endtask

    task automatic test_addi();
        run(4'd3, E_FETCH,  "addi_fetch");
        run(4'd3, E_DECODE, "addi_decode");
        run(4'd3, E_EXEC_I, "addi_exec_i");
        run(4'd3, E_WB_ALU, "addi_wb_alu");
        run_scoreboard();
    endtask

    task automatic test_load_store();
        run(4'd8, E_FETCH,    "load_fetch");
        run(4'd8, E_DECODE,   "load_decode");
        run(4'd8, E_EXEC_I,   "load_mem_addr");
        run(4'd8, E_MEM_READ, "load_mem_read");
        run(4'd8, E_WB_MEM,   "load_wb_mem");
        run(4'd9, E_FETCH,     "store_fetch");
        run(4'd9, E_DECODE,    "store_decode");
        run(4'd9, E_EXEC_I,    "store_mem_addr");
        run(4'd9, E_MEM_WRITE, "store_mem_write");
        run_scoreboard();
    endtask

    task automatic test_brz();
        // Branch taken: result_lsb is 1 in BR_TAKE.
        run(4'd10, E_FETCH,  "brz1_fetch");
        run(4'd10, E_DECODE, "brz1_decode");
        run(4'd10, E_EXEC_R, "brz1_cmp");
        push(1'b0, 1'b0, 4'd10, 1'b1, E_PC_EN, "brz1_take");
        // Not taken: result_lsb is 0 in BR_TAKE, while it is 1 in BR_CMP,
        // which must be ignored there.
        run(4'd10, E_FETCH,  "brz0_fetch");
        run(4'd10, E_DECODE, "brz0_decode");
        push(1'b0, 1'b0, 4'd10, 1'b1, E_EXEC_R, "brz0_cmp");
        push(1'b0, 1'b0, 4'd10, 1'b0, E_ZERO,   "brz0_take");
        run_scoreboard();
    endtask

    task automatic test_program_mode();
        run(4'd1, E_FETCH,  "pm_add_fetch");
        run(4'd1, E_DECODE, "pm_add_decode");
        push(1'b0, 1'b1, 4'd1, 1'b0, E_EXEC_R,  "pm_exec_r_abort");
        push(1'b0, 1'b1, 4'd1, 1'b0, E_PROGRAM, "pm_program_0");
        push(1'b0, 1'b1, 4'd1, 1'b0, E_PROGRAM, "pm_program_1");
        push(1'b0, 1'b0, 4'd1, 1'b0, E_PROGRAM, "pm_program_last");
        run(4'd0, E_FETCH,  "pm_exit_fetch");
        run(4'd0, E_DECODE, "pm_exit_decode");
        run_scoreboard();
    endtask

    task automatic test_halt();
        run(4'd15, E_FETCH,  "halt_fetch");
        run(4'd15, E_DECODE, "halt_decode");
        for (int i = 0; i < 5; i++) begin
            run(4'd3, E_ZERO, $sformatf("halt_idle_%0d", i));
        end
        // program_mode leaves HALT.
        push(1'b0, 1'b1, 4'd3, 1'b0, E_ZERO,    "halt_pm_req");
        push(1'b0, 1'b0, 4'd3, 1'b0, E_PROGRAM, "halt_to_program");
        run(4'd15, E_FETCH,  "halt2_fetch");
        run(4'd15, E_DECODE, "halt2_decode");
        run(4'd15, E_ZERO,   "halt2_idle_0");
        run(4'd15, E_ZERO,   "halt2_idle_1");
        run_scoreboard();

        // A reset pulse that does not span any clock edge must still drop the
        // outputs at once and leave the FSM in FETCH.
        @(posedge clk);
        #1;
        bus.opcode = 4'd0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== E_ZERO) begin
            n_fail++;
            $display("FAIL halt_async_reset_out: got %b expected %b", obs, E_ZERO);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== E_FETCH) begin
            n_fail++;
            $display("FAIL halt_async_reset_fetch: got %b expected %b", obs, E_FETCH);
        end
        run(4'd0, E_DECODE, "halt_reset_decode");
        run_scoreboard();
    endtask

    task automatic test_nop_reserved();
        logic [3:0] ops [3];
        ops[0] = 4'd0;
        ops[1] = 4'd13;
        ops[2] = 4'd14;
        for (int i = 0; i < 3; i++) begin
            run(ops[i], E_FETCH,  $sformatf("nop_op%0d_fetch", ops[i]));
            run(ops[i], E_DECODE, $sformatf("nop_op%0d_decode", ops[i]));
        end
        run_scoreboard();
    endtask

    task automatic test_back_to_back();
        run(4'd2,  E_FETCH,  "b2b_sub_fetch");
        run(4'd2,  E_DECODE, "b2b_sub_decode");
        run(4'd2,  E_EXEC_R, "b2b_sub_exec");
        run(4'd2,  E_WB_ALU, "b2b_sub_wb");
        run(4'd12, E_FETCH,  "b2b_li_fetch");
        run(4'd12, E_DECODE, "b2b_li_decode");
        run(4'd12, E_LI_WB,  "b2b_li_wb");
        run(4'd11, E_FETCH,  "b2b_jump_fetch");
        run(4'd11, E_DECODE, "b2b_jump_decode");
        run(4'd11, E_PC_EN,  "b2b_jump_pc");
        run(4'd7,  E_FETCH,  "b2b_slt_fetch");
        run(4'd7,  E_DECODE, "b2b_slt_decode");
        run(4'd7,  E_EXEC_R, "b2b_slt_exec");
        run(4'd7,  E_WB_ALU, "b2b_slt_wb");
        run(4'd0,  E_FETCH,  "b2b_final_fetch");
        run_scoreboard();
    endtask

    initial begin
        reset            = 1'b1;
        bus.program_mode = 1'b0;
        bus.opcode       = 4'd3;
        bus.result_lsb   = 1'b0;

        test_reset();
        test_addi();
        test_load_store();
        test_brz();
        test_program_mode();
        test_halt();
        test_nop_reserved();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore finite-state-machine control unit for a 4-bit-opcode multicycle computer. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath enable and select: IR, PC, ALU operand and output registers, data and instruction memories, and register-file writeback. A program mode streams instructions into instruction memory.

Parameters:
none (state encoding internal, binary, 4 bits)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; forces state FETCH
program_mode  in  1  1 = load instruction memory instead of executing
opcode  in  4  opcode field from instruction register, sampled in DECODE
result_lsb  in  1  LSB of ALU output register; branch condition
ir_enable  out  1  load instruction register
dmem_read  out  1  data memory read strobe
dmem_write  out  1  data memory write strobe
imem_read  out  1  instruction memory read strobe
imem_write  out  1  instruction memory write strobe
pc_increment  out  1  PC <= PC+1
alu_reg_enable  out  1  latch register-file operands A/B
pc_enable  out  1  PC <= target (branch/jump)
alu_src_B  out  1  ALU B mux: 0 = register B, 1 = immediate
alu_out_reg_enable  out  1  latch ALU result
dmem_out_reg_enable  out  1  latch data-memory output
reg_write_enable  out  1  register-file write
select_reg_write_data  out  2  writeback source: 0 = ALU out, 1 = dmem out, 2 = immediate, 3 = unused (0 data)

Behaviour:
Opcode map:
- 0 NOP
- 1 ADD, 2 SUB, 4 AND, 5 OR, 6 XOR, 7 SLT: R-type
- 3 ADDI
- 8 LOAD
- 9 STORE
- 10 BRZ: branch if result_lsb=1
- 11 JUMP
- 12 LI
- 13, 14: reserved, treated as NOP
- 15 HALT

Outputs:
- Outputs are a pure function of state.
- Every output not listed for a state is 0; select_reg_write_data defaults to 0.
- While reset=1, all outputs are 0.

States, asserted outputs, and next state:
- FETCH: imem_read, ir_enable, pc_increment -> DECODE
- DECODE: alu_reg_enable. Next state by opcode:
  - R-type -> EXEC_R
  - 3 -> EXEC_I
  - 8, 9 -> MEM_ADDR
  - 10 -> BR_CMP
  - 11 -> JUMP
  - 12 -> LI_WB
  - 15 -> HALT
  - 0, 13, 14 -> FETCH
- EXEC_R: alu_out_reg_enable (alu_src_B=0) -> WB_ALU
- EXEC_I: alu_src_B, alu_out_reg_enable -> WB_ALU
- WB_ALU: reg_write_enable, select=0 -> FETCH
- MEM_ADDR: alu_src_B, alu_out_reg_enable -> MEM_READ if opcode=8, MEM_WRITE if opcode=9
- MEM_READ: dmem_read, dmem_out_reg_enable -> WB_MEM
- WB_MEM: reg_write_enable, select=1 -> FETCH
- MEM_WRITE: dmem_write -> FETCH
- BR_CMP: alu_out_reg_enable (alu_src_B=0) -> BR_TAKE
- BR_TAKE: pc_enable = result_lsb (combinational from input, this state only) -> FETCH
- JUMP: pc_enable -> FETCH
- LI_WB: reg_write_enable, select=2 -> FETCH
- HALT: no outputs; remains in HALT until reset or program_mode
- PROGRAM: imem_write, pc_increment every cycle; when program_mode=0 -> FETCH

Priority and boundary rules:
- program_mode=1 at any rising edge (reset=0) sets next state to PROGRAM, aborting any in-flight instruction. No partial writes occur after that edge.
- Reset asynchronously forces FETCH from any state, including mid-instruction, PROGRAM and HALT. Outputs drop to 0 immediately.
- After reset deasserts, the first rising edge executes FETCH outputs, then proceeds normally.
- opcode is sampled only in DECODE and MEM_ADDR; it is ignored elsewhere.
- Illegal or unused state encodings -> FETCH.
- Cycle counts per instruction:
  - NOP, reserved opcodes: 2
  - JUMP, LI: 3
  - ADD/ADDI and other ALU ops: 4
  - BRZ: 4
  - STORE: 4
  - LOAD: 5

Test Plan:
- Reset then ADDI: hold reset=1 for one edge, release, opcode=3 -> outputs 0 during reset. Next cycles:
  - FETCH: imem_read=ir_enable=pc_increment=1
  - DECODE: alu_reg_enable=1
  - EXEC_I: alu_src_B=alu_out_reg_enable=1
  - WB_ALU: reg_write_enable=1, select=0
  - then FETCH
- LOAD (opcode=8) -> sequence FETCH, DECODE, MEM_ADDR (alu_src_B=1), MEM_READ (dmem_read=dmem_out_reg_enable=1), WB_MEM (reg_write_enable=1, select=1), FETCH. STORE (9) -> MEM_WRITE with dmem_write=1, 4 cycles total.
- BRZ (opcode=10):
  - with result_lsb=1: pc_enable=1 in BR_TAKE
  - repeat with result_lsb=0: pc_enable=0
  - both return to FETCH
- program_mode=1 asserted during EXEC_R -> next state PROGRAM with imem_write=pc_increment=1 each cycle. Deassert -> FETCH on the next edge.
- HALT (opcode=15) -> all outputs 0 for 5+ cycles. Async reset mid-HALT -> immediate FETCH state; outputs 0 while reset=1.
- opcode=0, 13, 14 -> FETCH, DECODE, FETCH; no reg_write_enable, dmem_write or pc_enable pulses.
